riscv_mem_stage: RTL and testbench
==================================

# riscv_mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM register outputs, runs a request/acknowledge transaction with the data memory for loads and stores, and requests pipeline stalls until the access completes. It also owns the MEM/WB register that drives write-back. Word-only accesses are supported; misaligned accesses and memory timeouts are reported and retired without a register write.

## Interface
- `TIMEOUT`, 16: maximum number of cycles `mem_req_o` stays high without `mem_ack_i` before the access is aborted (2..255).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall` in 5: pipeline stall vector. Bit 3 is this stage; bit 4 is write-back.
- `rd_idx_i` in `RegAddrBus`: destination register from EX/MEM.
- `rd_we_i` in 1: register write enable from EX/MEM.
- `data_i` in `MemDataBus`: ALU result for non-memory ops; store data for stores.
- `data_we_i` in 1: store.
- `data_re_i` in 1: load.
- `data_addr_i` in `MemAddrBus`: byte address.
- `mem_req_o` out 1: memory request, registered.
- `mem_we_o` out 1: write qualifier, registered.
- `mem_addr_o` out `MemAddrBus`: registered.
- `mem_wdata_o` out `MemDataBus`: registered.
- `mem_rdata_i` in `MemDataBus`: read data, valid when `mem_ack_i` is high.
- `mem_ack_i` in 1: completion. May be combinational in the first request cycle.
- `stallreq_o` out 1: combinational stall request to the stall controller.
- `wb_rd_idx_o` out `RegAddrBus`: MEM/WB register.
- `wb_rd_we_o` out 1: MEM/WB register.
- `wb_data_o` out `MemDataBus`: MEM/WB register.
- `misalign_o` out 1: one-cycle pulse, registered.
- `bus_err_o` out 1: one-cycle pulse, registered.

## Operation
- **States.**
  - IDLE: no transaction.
  - REQ: request outstanding.
  - DONE: result captured, waiting for the MEM/WB register to free up.
- **Access.** An access is `data_re_i | data_we_i`. It is misaligned if `data_addr_i[1:0] != 0`.
- **IDLE, aligned access.**
  - `stallreq_o` = 1 combinationally.
  - At the next edge, go to REQ and load `mem_req_o`=1, `mem_we_o`=`data_we_i`, `mem_addr_o`=`data_addr_i`, `mem_wdata_o`=`data_i`.
  - Clear the timeout counter.
- **IDLE, misaligned access.**
  - No request is issued and `stallreq_o` = 0.
  - The instruction retires through MEM/WB with `wb_rd_we_o` forced to 0.
  - `misalign_o` pulses in the same edge that MEM/WB captures the instruction.
- **IDLE, no access.** The instruction passes straight through: `wb_data_o`=`data_i`, `wb_rd_we_o`=`rd_we_i`.
- **REQ, waiting.**
  - `stallreq_o` = `!mem_ack_i`.
  - `mem_*` outputs hold stable until acknowledged.
  - The counter increments each cycle without an acknowledge.
- **REQ, acknowledge.**
  - Capture `mem_rdata_i` into the load buffer and drop `mem_req_o` at that edge.
  - If `stall[3]`=0, MEM/WB captures the result at that same edge and the state returns to IDLE.
  - Otherwise go to DONE.
- **REQ, timeout.**
  - Timeout occurs when the counter equals `TIMEOUT-1` with no acknowledge.
  - Abort: drop `mem_req_o`, pulse `bus_err_o`, and retire the instruction with `wb_rd_we_o`=0 (through DONE if `stall[3]`=1).
  - If the acknowledge and the timeout land in the same cycle, the acknowledge wins.
- **DONE.**
  - `stallreq_o` = 0 and no new request is issued. The inputs are frozen by the upstream stall.
  - On the first cycle with `stall[3]`=0, MEM/WB captures from the buffer and the state returns to IDLE.
- **Write-back value.**
  - Load: `wb_data_o` = captured read data, `wb_rd_we_o` = `rd_we_i`.
  - Store: `wb_rd_we_o` = 0.
  - `wb_rd_idx_o` = `rd_idx_i` in all cases.
- **MEM/WB register update rule.**
  - `stall[3]` && `!stall[4]`: load a bubble (all fields 0).
  - `stall[3]` && `stall[4]`: hold.
  - `!stall[3]`: load the next value, but only when no transaction is outstanding (IDLE with no aligned access, or REQ/DONE completing as above).
  - An IDLE cycle with an aligned access never writes MEM/WB. `stallreq_o` = 1 drives `stall[3]`.
- **Stray acknowledge.** `mem_ack_i` is ignored in IDLE and DONE.

## Timing
- **Reset.** Every output is 0, the state is IDLE, and the counter is 0. Reset mid-REQ drops `mem_req_o` at the reset edge; any later acknowledge is ignored.
- **Non-memory op.** Zero stall cycles; MEM/WB updates at the next edge.
- **Zero-wait memory.** Acknowledge arrives in the first REQ cycle.
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ with acknowledge, `stallreq_o`=0.
  - Edge ending cycle 1: MEM/WB captures.
  - Result: one stall cycle per access.
- **N wait cycles.** N+1 stall cycles.
- **Timeout.** `mem_req_o` is high for exactly `TIMEOUT` cycles. `bus_err_o` goes high for one cycle after the edge that ends the last of them, provided `stall[3]`=0.
- **Back-to-back accesses.** The second access's request rises one edge after the first acknowledge edge; there is no idle gap beyond the IDLE stall cycle.

## Test plan
- **ALU pass-through.** `rd_idx_i`=5, `rd_we_i`=1, `data_i`=0x1234, no access → next cycle `wb_rd_idx_o`=5, `wb_rd_we_o`=1, `wb_data_o`=0x1234, `stallreq_o` never 1.
- **Zero-wait load.** Load at 0x100 with rdata 0xDEADBEEF acknowledged in the first REQ cycle → `stallreq_o` high 1 cycle, `mem_addr_o`=0x100, `mem_we_o`=0, `wb_data_o`=0xDEADBEEF, `wb_rd_we_o`=1.
- **Delayed store.** Store 0xCAFE to 0x204, acknowledge after 3 wait cycles → `mem_*` stable for 4 cycles, `mem_wdata_o`=0xCAFE, `stallreq_o` high 4 cycles, `wb_rd_we_o`=0.
- **Misaligned and timeout.**
  - Load at 0x102 → no `mem_req_o`, `misalign_o` pulses once, `wb_rd_we_o`=0.
  - Aligned load with no acknowledge and `TIMEOUT`=4 → `mem_req_o` high 4 cycles, `bus_err_o` pulses once, `wb_rd_we_o`=0.
- **Write-back stall.** Acknowledge while `stall[4:3]`=11 for 2 cycles → DONE, MEM/WB held. When stall releases, `wb_data_o` = buffered rdata; no second request is issued.
- **Reset mid-request and stray acknowledge.**
  - Assert `rst` in REQ → `mem_req_o`=0 and all outputs 0 next cycle; a following acknowledge changes nothing.
  - Acknowledge in IDLE → ignored.

Source files
------------

// File: rtl/riscv_mem_stage.sv
// Memory-access stage: runs word load/store transactions with data memory,
// raises stall requests while an access is outstanding, and owns MEM/WB.
module riscv_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  stall,
  input  logic [4:0]  rd_idx_i,
  input  logic        rd_we_i,
  input  logic [31:0] data_i,
  input  logic        data_we_i,
  input  logic        data_re_i,
  input  logic [31:0] data_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stallreq_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic        wb_rd_we_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [31:0] buf_data;
  logic        buf_we;
  logic        buf_err;

  logic        access, misal, aligned, tmo, complete;
  logic [31:0] nxt_data;
  logic        nxt_we, nxt_mis, nxt_err;
  logic        unused_stall;

  assign unused_stall = ^stall[2:0];

  assign access  = data_re_i | data_we_i;
  assign misal   = access & (data_addr_i[1:0] != 2'b00);
  assign aligned = access & ~misal;
  // Acknowledge takes precedence over an expiring counter.
  assign tmo     = (state == REQ) && !mem_ack_i && (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    stallreq_o = 1'b0;
    complete   = 1'b0;
    nxt_data   = data_i;
    nxt_we     = rd_we_i;
    nxt_mis    = 1'b0;
    nxt_err    = 1'b0;
    case (state)
      IDLE: begin
        stallreq_o = aligned;
        complete   = !aligned;
        if (misal) begin
          nxt_we  = 1'b0;
          nxt_mis = 1'b1;
        end
      end
      REQ: begin
        // The timeout cycle retires the instruction, so it does not stall.
        stallreq_o = !mem_ack_i && !tmo;
        complete   = mem_ack_i || tmo;
        if (mem_ack_i) begin
          nxt_data = data_re_i ? mem_rdata_i : data_i;
          nxt_we   = rd_we_i & ~data_we_i;
        end else begin
          nxt_we  = 1'b0;
          nxt_err = 1'b1;
        end
      end
      DONE: begin
        complete = 1'b1;
        nxt_data = buf_data;
        nxt_we   = buf_we;
        nxt_err  = buf_err;
      end
      default: ;
    endcase
  end

  // MEM/WB register and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd_idx_o <= '0;
      wb_rd_we_o  <= 1'b0;
      wb_data_o   <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (stall[3] && !stall[4]) begin
        wb_rd_idx_o <= '0;
        wb_rd_we_o  <= 1'b0;
        wb_data_o   <= '0;
      end else if (!stall[3] && complete) begin
        wb_rd_idx_o <= rd_idx_i;
        wb_rd_we_o  <= nxt_we;
        wb_data_o   <= nxt_data;
        misalign_o  <= nxt_mis;
        bus_err_o   <= nxt_err;
      end
    end
  end

  // Transaction FSM, request registers and load buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      buf_data    <= '0;
      buf_we      <= 1'b0;
      buf_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned) begin
            state       <= REQ;
            cnt         <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_i;
          end
        end
        REQ: begin
          if (complete) begin
            mem_req_o <= 1'b0;
            buf_data  <= nxt_data;
            buf_we    <= nxt_we;
            buf_err   <= nxt_err;
            state     <= stall[3] ? DONE : IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (!stall[3]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed bench for riscv_mem_stage; the bench acts as stall controller
// (stall[3] = forced bit | stallreq_o) so REQ/ack timing is realistic.
module tb_riscv_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s3f, s4f;
  logic [4:0]  stall;
  logic [4:0]  rd_idx_i;
  logic        rd_we_i;
  logic [31:0] data_i;
  logic        data_we_i, data_re_i;
  logic [31:0] data_addr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        stallreq_o;
  logic [4:0]  wb_rd_idx_o;
  logic        wb_rd_we_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, bus_err_o;

  int total = 0;
  int bad   = 0;

  assign stall = {s4f, s3f | stallreq_o, 3'b000};

  always #5 clk = ~clk;

  riscv_mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_idx_i(rd_idx_i), .rd_we_i(rd_we_i), .data_i(data_i),
    .data_we_i(data_we_i), .data_re_i(data_re_i), .data_addr_i(data_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stallreq_o(stallreq_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_rd_we_o(wb_rd_we_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    rd_idx_i = '0; rd_we_i = 1'b0; data_i = '0;
    data_we_i = 1'b0; data_re_i = 1'b0; data_addr_i = '0;
  endtask

  initial begin
    int n;
    int sc;
    rst = 1'b1; s3f = 1'b0; s4f = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    nop();
    tick(); tick();
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_wbidx", 32'(wb_rd_idx_o), 32'd0);
    check("rst_wbwe", 32'(wb_rd_we_o), 32'd0);
    check("rst_wbdata", wb_data_o, 32'd0);
    check("rst_pulses", {30'd0, misalign_o, bus_err_o}, 32'd0);
    rst = 1'b0;

    // ALU pass-through
    rd_idx_i = 5'd5; rd_we_i = 1'b1; data_i = 32'h1234;
    #1 check("alu_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("alu_idx", 32'(wb_rd_idx_o), 32'd5);
    check("alu_we", 32'(wb_rd_we_o), 32'd1);
    check("alu_data", wb_data_o, 32'h1234);
    nop();

    // Zero-wait load
    rd_idx_i = 5'd7; rd_we_i = 1'b1; data_re_i = 1'b1; data_addr_i = 32'h100;
    #1 check("zw_stall0", 32'(stallreq_o), 32'd1);
    tick();
    check("zw_req", 32'(mem_req_o), 32'd1);
    check("zw_addr", mem_addr_o, 32'h100);
    check("zw_we", 32'(mem_we_o), 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1 check("zw_stall1", 32'(stallreq_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    check("zw_wbdata", wb_data_o, 32'hDEADBEEF);
    check("zw_wbwe", 32'(wb_rd_we_o), 32'd1);
    check("zw_wbidx", 32'(wb_rd_idx_o), 32'd7);
    check("zw_reqdrop", 32'(mem_req_o), 32'd0);
    nop();

    // Delayed store, ack after 3 wait cycles
    rd_idx_i = 5'd9; rd_we_i = 1'b1; data_we_i = 1'b1;
    data_addr_i = 32'h204; data_i = 32'hCAFE;
    sc = 0;
    #1 if (stallreq_o) sc++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack_i = 1'b1; mem_rdata_i = 32'h0; end
      #1 if (stallreq_o) sc++;
      check("st_req", 32'(mem_req_o), 32'd1);
      check("st_wdata", mem_wdata_o, 32'hCAFE);
      check("st_addr", mem_addr_o, 32'h204);
      check("st_mwe", 32'(mem_we_o), 32'd1);
      tick();
    end
    mem_ack_i = 1'b0;
    check("st_stallcnt", sc, 32'd4);
    check("st_wbwe", 32'(wb_rd_we_o), 32'd0);
    check("st_wbidx", 32'(wb_rd_idx_o), 32'd9);
    check("st_reqdrop", 32'(mem_req_o), 32'd0);
    nop();

    // Misaligned load
    rd_idx_i = 5'd3; rd_we_i = 1'b1; data_re_i = 1'b1; data_addr_i = 32'h102;
    #1 check("mis_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("mis_req", 32'(mem_req_o), 32'd0);
    check("mis_pulse", 32'(misalign_o), 32'd1);
    check("mis_wbwe", 32'(wb_rd_we_o), 32'd0);
    check("mis_wbidx", 32'(wb_rd_idx_o), 32'd3);
    nop();
    tick();
    check("mis_pulse_end", 32'(misalign_o), 32'd0);

    // Timeout: no acknowledge ever
    rd_idx_i = 5'd4; rd_we_i = 1'b1; data_re_i = 1'b1; data_addr_i = 32'h300;
    tick();
    n = 0;
    while (mem_req_o && n < 20) begin
      n++;
      tick();
    end
    nop();
    check("tmo_reqcycles", n, TMO);
    check("tmo_err", 32'(bus_err_o), 32'd1);
    check("tmo_wbwe", 32'(wb_rd_we_o), 32'd0);
    check("tmo_wbidx", 32'(wb_rd_idx_o), 32'd4);
    tick();
    check("tmo_err_end", 32'(bus_err_o), 32'd0);

    // Write-back stall: ack lands while stall[4:3]=11
    rd_idx_i = 5'd6; rd_we_i = 1'b1; data_re_i = 1'b1; data_addr_i = 32'h400;
    tick();
    check("wbs_req", 32'(mem_req_o), 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA1234; s3f = 1'b1; s4f = 1'b1;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    check("wbs_reqdrop", 32'(mem_req_o), 32'd0);
    check("wbs_hold_we", 32'(wb_rd_we_o), 32'd0);
    check("wbs_hold_data", wb_data_o, 32'd0);
    check("wbs_done_stall", 32'(stallreq_o), 32'd0);
    tick();
    check("wbs_noreq", 32'(mem_req_o), 32'd0);
    s3f = 1'b0; s4f = 1'b0;
    tick();
    check("wbs_data", wb_data_o, 32'h55AA1234);
    check("wbs_we", 32'(wb_rd_we_o), 32'd1);
    check("wbs_idx", 32'(wb_rd_idx_o), 32'd6);
    check("wbs_noreq2", 32'(mem_req_o), 32'd0);
    nop();
    tick();
    check("wbs_noreq3", 32'(mem_req_o), 32'd0);

    // Reset mid-request, then stray acknowledge in IDLE
    rd_idx_i = 5'd8; rd_we_i = 1'b1; data_re_i = 1'b1; data_addr_i = 32'h500;
    tick();
    check("rr_req", 32'(mem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    check("rr_reqdrop", 32'(mem_req_o), 32'd0);
    check("rr_wbdata", wb_data_o, 32'd0);
    check("rr_wbidx", 32'(wb_rd_idx_o), 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    #1 check("stray_stall", 32'(stallreq_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    check("stray_req", 32'(mem_req_o), 32'd0);
    check("stray_wbdata", wb_data_o, 32'd0);
    check("stray_wbwe", 32'(wb_rd_we_o), 32'd0);
    check("stray_err", 32'(bus_err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
